pipe_issue_ctrl: RTL and testbench
==================================

Name: pipe_issue_ctrl

Overview:
- In-order issue controller for the pipe_mips32 five-stage pipeline. Sits at the ID stage.
- Holds a register scoreboard and decides each cycle whether the decoded instruction may enter ID/EX. Otherwise it stalls IF/ID and injects a bubble.
- Also serialises branches and sequences HLT drain into a halted state. Software no longer needs dummy OR padding between dependent instructions.

Parameters:
- REG_AW, 5, register address width (32 GPRs; R0 never pending)
- MAX_INFLIGHT, 3, max issued-but-unretired instructions (EX, MEM, WB)
- WRITE_FIRST, 1, when 1 a retire to reg r in cycle t clears a hazard on r for issue in cycle t (register file writes before it is read)

Ports:
- clk1, input, 1, pipeline clock; all state updates on rising edge
- rst_n, input, 1, asynchronous active-low reset
- id_valid, input, 1, IF/ID holds a valid instruction
- id_rs, input, REG_AW, source reg 1
- id_rt, input, REG_AW, source reg 2
- id_use_rs, input, 1, instruction reads rs
- id_use_rt, input, 1, instruction reads rt
- id_wr, input, 1, instruction writes a register
- id_rd, input, REG_AW, destination reg (rd or rt per type, resolved by decoder)
- id_is_branch, input, 1, BEQZ/BNEQZ
- id_is_halt, input, 1, HLT
- br_resolve, input, 1, branch outcome known in EX (single-cycle pulse)
- br_taken, input, 1, qualified by br_resolve
- ret_valid, input, 1, an instruction retires from WB this cycle
- ret_wr, input, 1, retiring instruction writes a register
- ret_rd, input, REG_AW, retiring destination
- issue, output, 1, ID instruction advances to ID/EX this cycle
- stall_if, output, 1, hold PC and IF/ID
- bubble_ex, output, 1, load NOP into ID/EX
- flush_ifid, output, 1, discard wrong-path instruction in IF/ID
- halted, output, 1, pipeline drained after HLT; sticky
- sb_err, output, 1, sticky: retire to a non-pending reg, or in-flight underflow

Behaviour:
- State:
  - pend[r], 2-bit count per reg r = 1..31
  - infl, 2-bit in-flight count
  - br_wait, 1 bit
  - FSM RUN / DRAIN / HALTED
- On rst_n low (async): all pend = 0, infl = 0, br_wait = 0, FSM = RUN, halted = 0, sb_err = 0.
- Outputs while in reset: issue = 0, stall_if = 0, bubble_ex = 1, flush_ifid = 0.
- Hazard rule (combinational): hz = (id_use_rs & busy(id_rs)) | (id_use_rt & busy(id_rt)).
  - busy(r) = (r != 0) & (pend[r] != 0).
  - Exception: if WRITE_FIRST = 1 and ret_valid & ret_wr & ret_rd == r & pend[r] == 1, then busy(r) = 0.
  - WAW is not a hazard; counters absorb multiple pending writers.
- issue = id_valid & FSM == RUN & ~hz & ~br_wait & (infl < MAX_INFLIGHT, or a retire this cycle).
- stall_if = (id_valid & ~issue) | FSM != RUN.
- bubble_ex = ~issue.
- Zero-latency decision: issue, stall_if, bubble_ex and flush_ifid are all combinational.
- Scoreboard update per edge:
  - pend[id_rd] += (issue & id_wr & id_rd != 0).
  - pend[ret_rd] -= (ret_valid & ret_wr & ret_rd != 0).
  - Same register +1 and -1 in one cycle: count unchanged.
  - Decrement at 0: count stays 0, sb_err set.
- In-flight update per edge: infl += issue, infl -= ret_valid; both in one cycle leaves it unchanged. Underflow: hold at 0, set sb_err.
- Branch handling:
  - issue & id_is_branch sets br_wait.
  - br_resolve clears br_wait.
  - flush_ifid = br_resolve & br_taken. The IF/ID instruction is not issued that cycle, because br_wait is still 1.
  - br_resolve while br_wait = 0 is ignored; sb_err is unaffected.
- FSM:
  - RUN -> DRAIN on issue & id_is_halt. HLT counts in infl and retires with ret_wr = 0.
  - DRAIN -> HALTED when infl == 0 after update.
  - HALTED is terminal until rst_n.
  - halted = (FSM == HALTED), registered.
  - A branch resolving during DRAIN still pulses flush_ifid.
- Reset asserted mid-operation discards all pending state immediately; no retire is expected afterwards.

Test Plan:
- Program ADDI R1,R0,10 / ADDI R2,R0,20 / ADDI R3,R0,25 / ADD R4,R1,R2 / ADD R5,R4,R3 / HLT, no padding:
  - ADD R4 stalls until R2 retires (WRITE_FIRST = 1).
  - ADD R5 stalls 2 cycles behind ADD R4.
  - Final R4 = 30, R5 = 55.
  - halted = 1 exactly one edge after HLT retires.
- Independent stream of 6 ADDI to R1..R6: issue = 1 every cycle; infl never exceeds 3; zero stalls.
- Same-cycle retire of R7 (pend = 1) with ID reading R7: WRITE_FIRST = 1 gives issue = 1; WRITE_FIRST = 0 gives one extra stall cycle.
- Taken BEQZ:
  - br_wait blocks the next instruction.
  - On br_resolve & br_taken, flush_ifid = 1 for one cycle and issue = 0.
  - Not-taken case: the next instruction issues the cycle after resolve.
- Two writers to R9 in flight: pend[R9] = 2. A reader stalls until both retire. Retiring a write to R10 with pend = 0 sets sb_err = 1.
- rst_n pulsed low mid-stall with pend[R4] = 1 and FSM = DRAIN: all outputs go to reset values asynchronously; an R4 reader issues immediately after release.

Source files
------------

// File: rtl/pipe_issue_ctrl_if.sv
// ID-stage issue bundle: decoded instruction, branch resolve, WB retire
// in; issue/stall/bubble/flush decisions out.
interface pipe_issue_ctrl_if #(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_wr;
  logic [REG_AW-1:0] id_rd;
  logic              id_is_branch;
  logic              id_is_halt;
  logic              br_resolve;
  logic              br_taken;
  logic              ret_valid;
  logic              ret_wr;
  logic [REG_AW-1:0] ret_rd;
  logic              issue;
  logic              stall_if;
  logic              bubble_ex;
  logic              flush_ifid;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
    output id_wr, id_rd, id_is_branch, id_is_halt,
    output br_resolve, br_taken,
    output ret_valid, ret_wr, ret_rd,
    input  issue, stall_if, bubble_ex, flush_ifid
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
    input  id_wr, id_rd, id_is_branch, id_is_halt,
    input  br_resolve, br_taken,
    input  ret_valid, ret_wr, ret_rd,
    output issue, stall_if, bubble_ex, flush_ifid
  );
endinterface

// File: rtl/pipe_issue_ctrl.sv
// In-order issue controller: register scoreboard, branch serialisation
// and HLT drain. Ports: clk1, rst_n, bus (slave), halted, sb_err.
module pipe_issue_ctrl #(
  parameter int REG_AW       = 5,
  parameter int MAX_INFLIGHT = 3,
  parameter int WRITE_FIRST  = 1
) (
  input  logic            clk1,
  input  logic            rst_n,
  pipe_issue_ctrl_if.slave bus,
  output logic            halted,
  output logic            sb_err
);

  localparam int         NREG = 1 << REG_AW;
  localparam logic [1:0] MAXI = 2'(MAX_INFLIGHT);
  localparam bit         WF   = (WRITE_FIRST != 0);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] pend_q [NREG];
  logic [1:0] pend_d [NREG];
  logic [1:0] infl_q, infl_d;
  logic       br_wait_q, br_wait_d;
  logic       err_q, err_d;

  logic            ret_hit;
  logic            rs_busy;
  logic            rt_busy;
  logic            hz;
  logic            room;
  logic            issue;
  logic [NREG-1:0] inc_vec;
  logic [NREG-1:0] dec_vec;

  assign ret_hit = bus.ret_valid & bus.ret_wr;

  // A retire of the last pending writer is visible to the
  // same-cycle reader when the regfile writes first.
  assign rs_busy = (bus.id_rs != '0)
                 & (pend_q[bus.id_rs] != 2'd0)
                 & ~(WF & ret_hit
                     & (bus.ret_rd == bus.id_rs)
                     & (pend_q[bus.id_rs] == 2'd1));

  assign rt_busy = (bus.id_rt != '0)
                 & (pend_q[bus.id_rt] != 2'd0)
                 & ~(WF & ret_hit
                     & (bus.ret_rd == bus.id_rt)
                     & (pend_q[bus.id_rt] == 2'd1));

  assign hz = (bus.id_use_rs & rs_busy)
            | (bus.id_use_rt & rt_busy);

  assign room = (infl_q < MAXI) | bus.ret_valid;

  assign issue = rst_n & bus.id_valid
               & (state_q == RUN)
               & ~hz & ~br_wait_q & room;

  assign bus.issue      = issue;
  assign bus.bubble_ex  = ~issue;
  assign bus.stall_if   = rst_n
                        & ((bus.id_valid & ~issue)
                           | (state_q != RUN));
  assign bus.flush_ifid = rst_n & bus.br_resolve & bus.br_taken;

  assign halted = (state_q == HALTED);
  assign sb_err = err_q;

  // One-hot per-register increment/decrement requests; R0 excluded.
  assign inc_vec = (issue & bus.id_wr & (bus.id_rd != '0))
                 ? (NREG'(1) << bus.id_rd) : '0;
  assign dec_vec = (ret_hit & (bus.ret_rd != '0))
                 ? (NREG'(1) << bus.ret_rd) : '0;

  always_comb begin
    pend_d    = pend_q;
    infl_d    = infl_q;
    br_wait_d = br_wait_q;
    err_d     = err_q;
    state_d   = state_q;

    for (int r = 1; r < NREG; r++) begin
      unique case ({inc_vec[r], dec_vec[r]})
        2'b10: pend_d[r] = pend_q[r] + 2'd1;
        2'b01: begin
          if (pend_q[r] == 2'd0) err_d = 1'b1;
          else pend_d[r] = pend_q[r] - 2'd1;
        end
        default: ;
      endcase
    end

    unique case ({issue, bus.ret_valid})
      2'b10: infl_d = infl_q + 2'd1;
      2'b01: begin
        if (infl_q == 2'd0) err_d = 1'b1;
        else infl_d = infl_q - 2'd1;
      end
      default: ;
    endcase

    if (bus.br_resolve) br_wait_d = 1'b0;
    if (issue & bus.id_is_branch) br_wait_d = 1'b1;

    unique case (1'b1)
      (state_q == RUN): begin
        if (issue & bus.id_is_halt) state_d = DRAIN;
      end
      (state_q == DRAIN): begin
        if (infl_d == 2'd0) state_d = HALTED;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) pend_q[r] <= 2'd0;
      infl_q    <= 2'd0;
      br_wait_q <= 1'b0;
      err_q     <= 1'b0;
      state_q   <= RUN;
    end else begin
      pend_q    <= pend_d;
      infl_q    <= infl_d;
      br_wait_q <= br_wait_d;
      err_q     <= err_d;
      state_q   <= state_d;
    end
  end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Directed bench for pipe_issue_ctrl; u_wf1 uses WRITE_FIRST=1,
// u_wf0 (fed the same inputs) uses WRITE_FIRST=0.
module tb_pipe_issue_ctrl;

  logic clk1;
  logic rst_n;
  logic halted_a, err_a;
  logic halted_b, err_b;
  int   checks = 0;
  int   errors = 0;

  pipe_issue_ctrl_if #(.REG_AW(5)) ifa ();
  pipe_issue_ctrl_if #(.REG_AW(5)) ifb ();

  assign ifb.id_valid     = ifa.id_valid;
  assign ifb.id_rs        = ifa.id_rs;
  assign ifb.id_rt        = ifa.id_rt;
  assign ifb.id_use_rs    = ifa.id_use_rs;
  assign ifb.id_use_rt    = ifa.id_use_rt;
  assign ifb.id_wr        = ifa.id_wr;
  assign ifb.id_rd        = ifa.id_rd;
  assign ifb.id_is_branch = ifa.id_is_branch;
  assign ifb.id_is_halt   = ifa.id_is_halt;
  assign ifb.br_resolve   = ifa.br_resolve;
  assign ifb.br_taken     = ifa.br_taken;
  assign ifb.ret_valid    = ifa.ret_valid;
  assign ifb.ret_wr       = ifa.ret_wr;
  assign ifb.ret_rd       = ifa.ret_rd;

  pipe_issue_ctrl #(.WRITE_FIRST(1)) u_wf1 (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .bus    (ifa),
    .halted (halted_a),
    .sb_err (err_a)
  );

  pipe_issue_ctrl #(.WRITE_FIRST(0)) u_wf0 (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .bus    (ifb),
    .halted (halted_b),
    .sb_err (err_b)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ifa.id_valid     = 1'b0;
    ifa.id_rs        = '0;
    ifa.id_rt        = '0;
    ifa.id_use_rs    = 1'b0;
    ifa.id_use_rt    = 1'b0;
    ifa.id_wr        = 1'b0;
    ifa.id_rd        = '0;
    ifa.id_is_branch = 1'b0;
    ifa.id_is_halt   = 1'b0;
    ifa.br_resolve   = 1'b0;
    ifa.br_taken     = 1'b0;
    ifa.ret_valid    = 1'b0;
    ifa.ret_wr       = 1'b0;
    ifa.ret_rd       = '0;
  endtask

  task automatic nxt();
    @(posedge clk1);
    #1;
    idle();
  endtask

  task automatic do_reset();
    @(posedge clk1);
    #1;
    rst_n = 1'b0;
    idle();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic id_set(input logic [4:0] rs, input bit urs,
                        input logic [4:0] rt, input bit urt,
                        input bit wr, input logic [4:0] rd);
    ifa.id_valid  = 1'b1;
    ifa.id_rs     = rs;
    ifa.id_use_rs = urs;
    ifa.id_rt     = rt;
    ifa.id_use_rt = urt;
    ifa.id_wr     = wr;
    ifa.id_rd     = rd;
  endtask

  task automatic ret_set(input bit wr, input logic [4:0] rd);
    ifa.ret_valid = 1'b1;
    ifa.ret_wr    = wr;
    ifa.ret_rd    = rd;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    ifa.id_valid   = 1'b1;
    ifa.br_resolve = 1'b1;
    ifa.br_taken   = 1'b1;
    repeat (2) @(posedge clk1);
    #4;
    chk("rst_issue", ifa.issue, 0);
    chk("rst_stall", ifa.stall_if, 0);
    chk("rst_bubble", ifa.bubble_ex, 1);
    chk("rst_flush", ifa.flush_ifid, 0);
    chk("rst_halted", halted_a, 0);
    chk("rst_err", err_a, 0);

    // Dependent program then HLT
    do_reset();
    id_set(0, 1, 0, 0, 1, 1); #3;
    chk("p_addi1", ifa.issue, 1);
    nxt(); id_set(0, 1, 0, 0, 1, 2); #3;
    chk("p_addi2", ifa.issue, 1);
    nxt(); id_set(0, 1, 0, 0, 1, 3); #3;
    chk("p_addi3", ifa.issue, 1);
    nxt(); id_set(1, 1, 2, 1, 1, 4); ret_set(1, 1); #3;
    chk("p_add4_st_iss", ifa.issue, 0);
    chk("p_add4_st_stall", ifa.stall_if, 1);
    chk("p_add4_st_bub", ifa.bubble_ex, 1);
    nxt(); id_set(1, 1, 2, 1, 1, 4); ret_set(1, 2); #3;
    chk("p_add4_go", ifa.issue, 1);
    chk("p_add4_go_stall", ifa.stall_if, 0);
    nxt(); id_set(4, 1, 3, 1, 1, 5); ret_set(1, 3); #3;
    chk("p_add5_st1", ifa.issue, 0);
    nxt(); id_set(4, 1, 3, 1, 1, 5); #3;
    chk("p_add5_st2", ifa.issue, 0);
    nxt(); id_set(4, 1, 3, 1, 1, 5); ret_set(1, 4); #3;
    chk("p_add5_go", ifa.issue, 1);
    nxt(); id_set(0, 0, 0, 0, 0, 0); ifa.id_is_halt = 1'b1; #3;
    chk("p_hlt_issue", ifa.issue, 1);
    nxt(); #3;
    chk("p_drain_stall", ifa.stall_if, 1);
    nxt(); ret_set(1, 5); #3;
    chk("p_drain_h0", halted_a, 0);
    nxt(); ret_set(0, 0); #3;
    chk("p_hltret_h0", halted_a, 0);
    nxt(); id_set(0, 1, 0, 0, 1, 1); #3;
    chk("p_halted", halted_a, 1);
    chk("p_halted_iss", ifa.issue, 0);
    chk("p_halted_stall", ifa.stall_if, 1);
    chk("p_err", err_a, 0);

    // Independent stream
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      id_set(0, 1, 0, 0, 1, 5'(i));
      if (i >= 4) ret_set(1, 5'(i - 3));
      #3;
      chk($sformatf("ind_iss%0d", i), ifa.issue, 1);
      chk($sformatf("ind_stall%0d", i), ifa.stall_if, 0);
      nxt();
    end
    for (int i = 4; i <= 6; i++) begin
      ret_set(1, 5'(i));
      nxt();
    end
    #3;
    chk("ind_err", err_a, 0);

    // Same-cycle retire of R7, both WRITE_FIRST settings
    do_reset();
    id_set(0, 1, 0, 0, 1, 7); #3;
    chk("r7_wr_issue", ifa.issue, 1);
    nxt(); nxt(); nxt();
    id_set(7, 1, 0, 0, 0, 0); ret_set(1, 7); #3;
    chk("r7_wf1_issue", ifa.issue, 1);
    chk("r7_wf0_issue", ifb.issue, 0);
    chk("r7_wf0_stall", ifb.stall_if, 1);
    nxt(); id_set(7, 1, 0, 0, 0, 0); #3;
    chk("r7_wf0_late", ifb.issue, 1);
    chk("r7_wf0_err", err_b, 0);

    // Branches
    do_reset();
    id_set(1, 1, 0, 0, 0, 0); ifa.id_is_branch = 1'b1; #3;
    chk("br_issue", ifa.issue, 1);
    nxt(); id_set(0, 1, 0, 0, 1, 1);
    ifa.br_resolve = 1'b1; ifa.br_taken = 1'b1; #3;
    chk("brt_flush", ifa.flush_ifid, 1);
    chk("brt_iss", ifa.issue, 0);
    chk("brt_stall", ifa.stall_if, 1);
    nxt(); id_set(0, 1, 0, 0, 1, 1); #3;
    chk("brt_tgt_iss", ifa.issue, 1);
    chk("brt_tgt_flush", ifa.flush_ifid, 0);
    nxt(); id_set(2, 1, 0, 0, 0, 0); ifa.id_is_branch = 1'b1;
    ret_set(0, 0); #3;
    chk("brn_issue", ifa.issue, 1);
    nxt(); id_set(0, 1, 0, 0, 1, 3); ifa.br_resolve = 1'b1; #3;
    chk("brn_flush", ifa.flush_ifid, 0);
    chk("brn_blk", ifa.issue, 0);
    nxt(); id_set(0, 1, 0, 0, 1, 3); ret_set(1, 1); #3;
    chk("brn_next", ifa.issue, 1);
    chk("br_err", err_a, 0);

    // Two writers to R9, then bad retire of R10
    do_reset();
    id_set(0, 1, 0, 0, 1, 9); #3;
    chk("waw_1", ifa.issue, 1);
    nxt(); id_set(0, 1, 0, 0, 1, 9); #3;
    chk("waw_2", ifa.issue, 1);
    nxt(); id_set(0, 0, 9, 1, 0, 0); #3;
    chk("waw_rd_st0", ifa.issue, 0);
    nxt(); id_set(0, 0, 9, 1, 0, 0); ret_set(1, 9); #3;
    chk("waw_rd_st1", ifa.issue, 0);
    nxt(); id_set(0, 0, 9, 1, 0, 0); ret_set(1, 9); #3;
    chk("waw_rd_go", ifa.issue, 1);
    nxt(); ret_set(1, 10); #3;
    chk("r10_err_pre", err_a, 0);
    nxt(); #3;
    chk("r10_err", err_a, 1);

    // Async reset mid-stall during DRAIN
    do_reset();
    id_set(0, 1, 0, 0, 1, 4); #3;
    chk("ar_wr4", ifa.issue, 1);
    nxt(); id_set(0, 0, 0, 0, 0, 0); ifa.id_is_halt = 1'b1; #3;
    chk("ar_hlt", ifa.issue, 1);
    nxt(); id_set(4, 1, 0, 0, 1, 5); #3;
    chk("ar_stall_pre", ifa.stall_if, 1);
    ifa.br_resolve = 1'b1; ifa.br_taken = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("ar_issue", ifa.issue, 0);
    chk("ar_stall", ifa.stall_if, 0);
    chk("ar_bubble", ifa.bubble_ex, 1);
    chk("ar_flush", ifa.flush_ifid, 0);
    chk("ar_halted", halted_a, 0);
    rst_n = 1'b1;
    ifa.br_resolve = 1'b0; ifa.br_taken = 1'b0;
    #1;
    chk("ar_rel_issue", ifa.issue, 1);
    chk("ar_rel_stall", ifa.stall_if, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
